bus_arbiter_2x1: RTL
====================

Name: bus_arbiter_2x1

Overview:
- Round-robin arbiter that shares the 16-bit 2:1 operand mux between two requesters, for example a register-file read port and the immediate/fetch path.
- It drives the mux select, returns per-requester grants and registers the selected word onto a shared bus with a valid strobe.
- Bursts are bounded so that neither requester can starve the other.

Parameters:
- WIDTH, 16, data width of each requester input and of bus_out.
- MAX_BURST, 4, maximum consecutive transfers for one owner while the other requester is waiting; must be >= 1.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 wants the bus; held high for as long as it has data.
- req1  input  1  requester 1 wants the bus.
- data0  input  WIDTH  requester 0 word.
- data1  input  WIDTH  requester 1 word.
- gnt0  output  1  requester 0 owns the bus.
- gnt1  output  1  requester 1 owns the bus.
- mux_sel  output  1  select for the shared mux: 0 = data0, 1 = data1.
- bus_out  output  WIDTH  registered transferred word.
- bus_valid  output  1  bus_out holds a word captured at the last edge.
- bus_owner  output  1  index of the requester whose word is on bus_out.

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset (applied immediately, regardless of clk):
  - State goes to IDLE.
  - gnt0, gnt1, mux_sel, bus_out, bus_valid, bus_owner all go to 0.
  - Burst counter goes to 0.
  - last_owner goes to 1, so requester 0 wins the first tie.
- State machine has three states: IDLE, GRANT0, GRANT1.
- Output decode is taken straight from the state register, with no combinational path from inputs:
  - gnt0 = (state == GRANT0).
  - gnt1 = (state == GRANT1).
  - mux_sel = (state == GRANT1).
- IDLE transitions:
  - Only req0 high: go to GRANT0.
  - Only req1 high: go to GRANT1.
  - Both high: grant the requester that is not last_owner.
  - Neither high: stay in IDLE.
  - last_owner is updated on every entry into a grant state.
  - Latency is 1 cycle from a sampled request to its grant.
- Transfer rule, at each edge:
  - bus_valid <= (GRANT0 and req0) or (GRANT1 and req1).
  - When valid: bus_out <= the word selected by mux_sel, and bus_owner <= mux_sel.
  - When not valid: bus_out and bus_owner hold their values, and bus_valid goes to 0.
  - First word appears 2 edges after the request is asserted from IDLE.
- Transitions out of GRANTn (n = current owner, m = other):
  - reqn low: go to GRANTm if reqm is high, otherwise IDLE. No transfer happens on this edge.
  - reqn high and counter == MAX_BURST-1 and reqm high: transfer, then go to GRANTm. Switch-over has no idle cycle, so bus_valid stays high continuously.
  - reqn high otherwise: transfer and stay in GRANTn. The counter increments, wrapping to 0 after MAX_BURST-1. A sole requester keeps the bus indefinitely.
  - The counter clears to 0 on every state change.
- Counter width is clog2(MAX_BURST), with a minimum of 1 bit.
- With MAX_BURST = 1 and both requesters active, ownership alternates on every transfer.
- Simultaneous events:
  - reqn dropping while reqm rises on the same edge: hand over to m.
  - Both requests dropping: go to IDLE.
- Reset mid-burst aborts the burst without completing it. After rst_n rises, arbitration restarts with requester-0 priority on a tie.
- Requests that arrive while the other requester owns the bus are not queued beyond the level of the req signal. A requester must hold req until its gnt is seen.

Test Plan:
- Reset check: assert rst_n=0 between clock edges with random inputs -> all outputs are 0 immediately; after release, state is IDLE and gnt0=gnt1=0.
- Single requester, req0 only: req0=1 for 3 cycles with data0=16'b0000_1111_0000_1111 -> gnt0=1 after edge 1; bus_valid=1 with bus_out=0F0F and bus_owner=0 after edges 2, 3 and 4; after req0 drops, bus_valid=0 and state is IDLE.
- Contention, MAX_BURST=4: req0 and req1 both asserted from reset, data0=16'h0F0F, data1=16'hF0F0:
  - Grant goes to gnt0 first.
  - Four words of 0F0F appear, then gnt1 on the next cycle with no valid gap.
  - Four words of F0F0 follow, then ownership returns to requester 0.
- Sole long burst: req1 held for 10 cycles with req0=0 -> gnt1 stays high throughout, 10 consecutive valid words appear with bus_owner=1, and the counter wraps without a handover.
- Handover on request drop: while in GRANT0, req0 falls and req1 rises on the same edge -> state goes straight to GRANT1 with no transfer of data0 on that edge.
- Reset mid-burst: rst_n is pulsed low during the 2nd transfer of a GRANT1 burst -> outputs clear asynchronously; after release with both requests high, gnt0 wins.

Source files
------------

// File: rtl/bus_arbiter_2x1.sv
// Round-robin 2:1 bus arbiter with bounded bursts. Drives the shared operand
// mux select and registers the selected word onto bus_out with a valid strobe.
module bus_arbiter_2x1 #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             mux_sel,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_valid,
  output logic             bus_owner
);

  localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_owner, last_owner_nxt;
  logic          xfer;

  assign gnt0    = (state == GRANT0);
  assign gnt1    = (state == GRANT1);
  assign mux_sel = (state == GRANT1);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_owner_nxt = last_owner;
    xfer           = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last_owner ? GRANT0 : GRANT1;
        else if (req0)     state_nxt = GRANT0;
        else if (req1)     state_nxt = GRANT1;
      end
      GRANT0: begin
        if (!req0) begin
          state_nxt = req1 ? GRANT1 : IDLE;
        end else begin
          xfer = 1'b1;
          if (cnt == CNT_LAST && req1) state_nxt = GRANT1;
        end
      end
      GRANT1: begin
        if (!req1) begin
          state_nxt = req0 ? GRANT0 : IDLE;
        end else begin
          xfer = 1'b1;
          if (cnt == CNT_LAST && req0) state_nxt = GRANT0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Counter tracks transfers within one tenure; any state change restarts it.
    if (state_nxt != state) begin
      cnt_nxt = '0;
      if (state_nxt == GRANT0) last_owner_nxt = 1'b0;
      if (state_nxt == GRANT1) last_owner_nxt = 1'b1;
    end else if (xfer) begin
      cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= 1'b1;
      bus_out    <= '0;
      bus_valid  <= 1'b0;
      bus_owner  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_owner <= last_owner_nxt;
      bus_valid  <= xfer;
      if (xfer) begin
        bus_out   <= mux_sel ? data1 : data0;
        bus_owner <= mux_sel;
      end
    end
  end

endmodule
